// File: rtl/fifo_pkg.sv
// Shared definitions for the four-way FIFO bank.
// Holds the default word width and depth, the number of FIFOs in the bank,
// and the address width that follows from the default depth.
package fifo_pkg;

  localparam int WORD_SIZE_DEF  = 12;
  localparam int DEPTH_DEF      = 8;
  localparam int NUM_FIFOS      = 4;
  localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);

endpackage : fifo_pkg

// File: rtl/fifo_sync.sv
// One synchronous FIFO with registered read data and a sticky error flag.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   push, data_in       - write strobe and write word
//   pop, data_out       - read strobe and registered read word (held between pops)
//   empty, almost_full,
//   full                - decoded from the count register only
//   error               - sticky; set on overflow or underflow, cleared by reset
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int AF_THRESHOLD = DEPTH_DEF - 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 pop,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 full,
  output logic                 error
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = AF_THRESHOLD[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [WORD_SIZE-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic [WORD_SIZE-1:0]  data_out_q;
  logic                  push_ok, pop_ok;

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign almost_full = (count_q >= AF_CNT);
  assign error       = error_q;
  assign data_out    = data_out_q;

  // A push into a full FIFO is accepted only when a pop frees the slot on the
  // same edge. A pop on an empty FIFO is never accepted, even alongside a push
  // (no fall-through), and is flagged as an underflow.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if ((push && full && !pop) || (pop && empty)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
      if (pop_ok) begin
        data_out_q <= mem[rd_ptr_q];
      end
    end
  end

  // Storage is not cleared by reset; a push coinciding with reset is dropped.
  // When full with push and pop together, wr_ptr equals rd_ptr: the read above
  // sees the old word while this write replaces it.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

endmodule : fifo_sync

// File: rtl/fifo_bank4.sv
// Bank of four independent FIFOs fed by the arbiter.
// Ports:
//   clk, reset                 - clock and synchronous active-high reset
//   fifos_push, fifo_data_in   - per-FIFO write strobes and shared write word
//   fifos_pop                  - per-FIFO read strobes from the next stage
//   fifo_data_out0..3          - registered read data per FIFO
//   fifos_empty/almost_full/
//   fifos_full/fifos_error     - per-FIFO status, bit i belongs to FIFO i
module fifo_bank4
  import fifo_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int AF_THRESHOLD = DEPTH_DEF - 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           fifos_push,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic [3:0]           fifos_pop,
  output logic [WORD_SIZE-1:0] fifo_data_out0,
  output logic [WORD_SIZE-1:0] fifo_data_out1,
  output logic [WORD_SIZE-1:0] fifo_data_out2,
  output logic [WORD_SIZE-1:0] fifo_data_out3,
  output logic [3:0]           fifos_empty,
  output logic [3:0]           fifos_almost_full,
  output logic [3:0]           fifos_full,
  output logic [3:0]           fifos_error
);

  logic [WORD_SIZE-1:0] data_out_w [NUM_FIFOS];

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
    fifo_sync #(
      .WORD_SIZE   (WORD_SIZE),
      .DEPTH       (DEPTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .AF_THRESHOLD(AF_THRESHOLD)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifos_push[gi]),
      .data_in    (fifo_data_in),
      .pop        (fifos_pop[gi]),
      .data_out   (data_out_w[gi]),
      .empty      (fifos_empty[gi]),
      .almost_full(fifos_almost_full[gi]),
      .full       (fifos_full[gi]),
      .error      (fifos_error[gi])
    );
  end

  assign fifo_data_out0 = data_out_w[0];
  assign fifo_data_out1 = data_out_w[1];
  assign fifo_data_out2 = data_out_w[2];
  assign fifo_data_out3 = data_out_w[3];

endmodule : fifo_bank4

// File: tb/tb_fifo_bank4.sv
// Directed self-checking bench for fifo_bank4 with default parameters
// (12-bit words, depth 8, almost-full at 6).
module tb_fifo_bank4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fifos_push;
  logic [11:0] fifo_data_in;
  logic [3:0]  fifos_pop;
  logic [11:0] fifo_data_out0, fifo_data_out1, fifo_data_out2, fifo_data_out3;
  logic [3:0]  fifos_empty, fifos_almost_full, fifos_full, fifos_error;

  int n_asserts = 0;
  int n_fail    = 0;

  fifo_bank4 dut (
    .clk              (clk),
    .reset            (reset),
    .fifos_push       (fifos_push),
    .fifo_data_in     (fifo_data_in),
    .fifos_pop        (fifos_pop),
    .fifo_data_out0   (fifo_data_out0),
    .fifo_data_out1   (fifo_data_out1),
    .fifo_data_out2   (fifo_data_out2),
    .fifo_data_out3   (fifo_data_out3),
    .fifos_empty      (fifos_empty),
    .fifos_almost_full(fifos_almost_full),
    .fifos_full       (fifos_full),
    .fifos_error      (fifos_error)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [11:0] fill_tbl [8];

  initial begin
    fill_tbl[0] = 12'h34C; fill_tbl[1] = 12'h2CC; fill_tbl[2] = 12'hB4C; fill_tbl[3] = 12'h1A5;
    fill_tbl[4] = 12'h7E2; fill_tbl[5] = 12'h0F3; fill_tbl[6] = 12'hC61; fill_tbl[7] = 12'h5D8;

    // Reset held two cycles while every push strobe is high.
    reset = 1'b1; fifos_push = 4'b1111; fifos_pop = 4'b0000; fifo_data_in = 12'hABC;
    tick(); tick();
    check("rst_empty", 32'(fifos_empty), 32'hF);
    check("rst_af",    32'(fifos_almost_full), 32'h0);
    check("rst_full",  32'(fifos_full), 32'h0);
    check("rst_err",   32'(fifos_error), 32'h0);
    check("rst_dout",  32'({fifo_data_out0, fifo_data_out1, fifo_data_out2, fifo_data_out3}), 32'h0);
    reset = 1'b0; fifos_push = 4'b0000;

    // Fill FIFO 0; flags follow the count after each push.
    for (int i = 0; i < 8; i++) begin
      fifos_push = 4'b0001; fifo_data_in = fill_tbl[i];
      tick();
      $display("push f0 #%0d data=%03h empty=%b af=%b full=%b", i + 1, fill_tbl[i],
               fifos_empty[0], fifos_almost_full[0], fifos_full[0]);
      check("fill_empty0", 32'(fifos_empty[0]), 32'h0);
      check("fill_af0",    32'(fifos_almost_full[0]), 32'((i + 1) >= 6));
      check("fill_full0",  32'(fifos_full[0]), 32'((i + 1) == 8));
    end
    check("fill_err0_before", 32'(fifos_error[0]), 32'h0);
    fifo_data_in = 12'h999;
    tick();
    fifos_push = 4'b0000;
    check("ovf_err0",  32'(fifos_error[0]), 32'h1);
    check("ovf_full0", 32'(fifos_full[0]), 32'h1);
    // Drain: the overflowed word must not have replaced entry 0.
    for (int i = 0; i < 8; i++) begin
      fifos_pop = 4'b0001;
      tick();
      $display("pop f0 #%0d data=%03h", i + 1, fifo_data_out0);
      check("drain_dout0", 32'(fifo_data_out0), 32'(fill_tbl[i]));
    end
    fifos_pop = 4'b0000;
    check("drain_empty0", 32'(fifos_empty[0]), 32'h1);

    // FIFO 2 order and pointer wrap: two rounds of 6 push / 6 pop.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 6; k++) begin
        fifos_push = 4'b0100; fifo_data_in = 12'(12'h200 + r * 16 + k);
        tick();
        $display("push f2 data=%03h", fifo_data_in);
      end
      fifos_push = 4'b0000;
      for (int k = 0; k < 6; k++) begin
        fifos_pop = 4'b0100;
        tick();
        $display("pop f2 data=%03h", fifo_data_out2);
        check("order_dout2", 32'(fifo_data_out2), 32'(12'h200 + r * 16 + k));
      end
      fifos_pop = 4'b0000;
    end
    check("wrap_err2",   32'(fifos_error[2]), 32'h0);
    check("wrap_empty2", 32'(fifos_empty[2]), 32'h1);

    // Full FIFO 1 with push and pop together.
    for (int k = 0; k < 8; k++) begin
      fifos_push = 4'b0010; fifo_data_in = 12'(12'h100 + k);
      tick();
    end
    check("f1_full", 32'(fifos_full[1]), 32'h1);
    fifos_push = 4'b0010; fifos_pop = 4'b0010; fifo_data_in = 12'h1FF;
    tick();
    $display("push+pop f1 full data_in=1ff data_out=%03h", fifo_data_out1);
    fifos_push = 4'b0000; fifos_pop = 4'b0000;
    check("pp_full_dout1", 32'(fifo_data_out1), 32'h100);
    check("pp_full_full1", 32'(fifos_full[1]), 32'h1);
    check("pp_full_err1",  32'(fifos_error[1]), 32'h0);
    for (int k = 1; k < 9; k++) begin
      fifos_pop = 4'b0010;
      tick();
      $display("pop f1 data=%03h", fifo_data_out1);
      check("pp_drain_dout1", 32'(fifo_data_out1), (k == 8) ? 32'h1FF : 32'(12'h100 + k));
    end
    fifos_pop = 4'b0000;
    check("pp_drain_empty1", 32'(fifos_empty[1]), 32'h1);

    // Empty FIFO 3 with push and pop together: push lands, pop is an underflow.
    fifos_push = 4'b1000; fifos_pop = 4'b1000; fifo_data_in = 12'h3AA;
    tick();
    $display("push+pop f3 empty data_in=3aa data_out=%03h", fifo_data_out3);
    fifos_push = 4'b0000; fifos_pop = 4'b0000;
    check("pp_empty_empty3", 32'(fifos_empty[3]), 32'h0);
    check("pp_empty_err3",   32'(fifos_error[3]), 32'h1);
    check("pp_empty_dout3",  32'(fifo_data_out3), 32'h0);
    fifos_pop = 4'b1000;
    tick();
    fifos_pop = 4'b0000;
    check("pp_empty_pop3",    32'(fifo_data_out3), 32'h3AA);
    check("pp_empty_after3",  32'(fifos_empty[3]), 32'h1);

    // Independence: push to FIFOs 1 and 3 only.
    fifos_push = 4'b1010; fifo_data_in = 12'hF0F;
    tick();
    fifos_push = 4'b0000;
    $display("push 1010 data=f0f empty=%b", fifos_empty);
    check("ind_empty", 32'(fifos_empty), 32'h5);
    fifos_pop = 4'b1010;
    tick();
    fifos_pop = 4'b0000;
    $display("pop 1010 d1=%03h d3=%03h", fifo_data_out1, fifo_data_out3);
    check("ind_dout1", 32'(fifo_data_out1), 32'hF0F);
    check("ind_dout3", 32'(fifo_data_out3), 32'hF0F);
    check("ind_empty_after", 32'(fifos_empty), 32'hF);
    check("ind_err", 32'(fifos_error), 32'h9);

    // Reset mid-operation with push and pop on the same edge.
    for (int k = 0; k < 5; k++) begin
      fifos_push = 4'b0001; fifo_data_in = 12'(12'h501 + k);
      tick();
    end
    reset = 1'b1; fifos_push = 4'b0001; fifos_pop = 4'b0001; fifo_data_in = 12'hEAD;
    tick();
    reset = 1'b0; fifos_push = 4'b0000; fifos_pop = 4'b0000;
    $display("reset mid-op empty=%b err=%b d0=%03h", fifos_empty, fifos_error, fifo_data_out0);
    check("mid_rst_empty", 32'(fifos_empty), 32'hF);
    check("mid_rst_err",   32'(fifos_error), 32'h0);
    check("mid_rst_dout0", 32'(fifo_data_out0), 32'h0);
    check("mid_rst_af",    32'(fifos_almost_full), 32'h0);
    fifos_push = 4'b0001; fifo_data_in = 12'h777;
    tick();
    fifos_push = 4'b0000; fifos_pop = 4'b0001;
    tick();
    fifos_pop = 4'b0000;
    $display("post-reset push/pop f0 data=%03h", fifo_data_out0);
    check("mid_rst_new0",   32'(fifo_data_out0), 32'h777);
    check("mid_rst_empty0", 32'(fifos_empty[0]), 32'h1);
    check("mid_rst_err0",   32'(fifos_error[0]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule : tb_fifo_bank4

// File: doc/fifo_bank4.md
# fifo_bank4

Bank of four independent synchronous FIFOs that sits directly downstream of the 4-way arbiter (arbitro1). It absorbs the arbiter's per-destination push strobes and shared data word, and buffers each destination class separately. It returns per-FIFO `fifos_empty` and `fifos_almost_full` to the arbiter and to the next stage. The next stage drains each FIFO through its own pop strobe and data output.

## Interface
Parameters:
- `WORD_SIZE`, 12: data word width.
- `DEPTH`, 8: entries per FIFO; must be a power of two, ≥4.
- `ADDR_WIDTH`, 3: log2(DEPTH).
- `AF_THRESHOLD`, 6: `fifos_almost_full[i]` asserts when count ≥ this value; 1 ≤ value ≤ DEPTH.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifos_push`  in  4  per-FIFO write strobe; bit i writes `fifo_data_in` into FIFO i.
- `fifo_data_in`  in  WORD_SIZE  shared write data from the arbiter.
- `fifos_pop`  in  4  per-FIFO read strobe from the downstream stage.
- `fifo_data_out0..3`  out  WORD_SIZE  registered read data of FIFO 0..3.
- `fifos_empty`  out  4  bit i = FIFO i count == 0.
- `fifos_almost_full`  out  4  bit i = FIFO i count ≥ AF_THRESHOLD.
- `fifos_full`  out  4  bit i = FIFO i count == DEPTH.
- `fifos_error`  out  4  sticky; bit i set on overflow or underflow of FIFO i.

## Operation
- Each FIFO holds:
  - a DEPTH × WORD_SIZE array,
  - a write pointer and a read pointer, each ADDR_WIDTH bits, wrapping modulo DEPTH,
  - a count of ADDR_WIDTH+1 bits.
- Push to FIFO i:
  - not full: write `fifo_data_in` at wr_ptr, then wr_ptr++.
  - full and no pop: data is dropped, pointers unchanged, `fifos_error[i]` is set.
- Pop from FIFO i:
  - not empty: `fifo_data_out_i` <= mem[rd_ptr], then rd_ptr++.
  - empty and no push: ignored; `fifo_data_out_i` holds its value and `fifos_error[i]` is set.
- Simultaneous push and pop on the same FIFO:
  - 0 < count < DEPTH: both are performed; count is unchanged.
  - full: both are performed, because the pop frees the slot in the same edge; count stays DEPTH; no error.
  - empty: the push is performed and the pop is ignored (no fall-through); count becomes 1; the error bit is set.
- Count update: +1 on an accepted push only, −1 on an accepted pop only, unchanged otherwise. It never goes below 0 or above DEPTH.
- Flags are decoded combinationally from the count register only. They never depend on the current-cycle strobes.
- Multiple push bits may be high at once. Each addressed FIFO stores the same `fifo_data_in`.
- `fifos_error` clears only on reset.

## Timing
- Reset, applied at any edge including mid-traffic:
  - pointers = 0, counts = 0;
  - `fifos_empty` = 4'b1111;
  - `fifos_almost_full`, `fifos_full`, `fifos_error` = 0;
  - all `fifo_data_out*` = 0.
  - Memory contents are not cleared.
  - Reset has priority over push and pop in the same cycle.
- Write-to-flag latency is 1: a push sampled at edge N deasserts `fifos_empty[i]` in the cycle after edge N.
- Read latency is 1: a pop sampled at edge N presents data on `fifo_data_out_i` after edge N. The data holds until the next accepted pop or reset.
- Minimum write-to-read: a push at edge N allows a pop at edge N+1, with data visible after edge N+1.
- Default AF_THRESHOLD = DEPTH−2 leaves two entries of slack. This covers one registered cycle of push strobes in flight in the arbiter after `almost_full` rises.

## Structure
- Shared package `fifo_pkg`:
  - defaults `WORD_SIZE_DEF` = 12, `DEPTH_DEF` = 8, `NUM_FIFOS` = 4;
  - the `clog2`-style address-width constant.
- Sub-module `fifo_sync` holds one FIFO: array, pointers, count, flags, and sticky error.
- `fifo_bank4` instantiates four `fifo_sync` instances. It fans out `fifo_data_in`, splits the strobe vectors, and packs the flag vectors.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles with `fifos_push`=4'b1111 → `fifos_empty`=4'b1111, `fifos_almost_full`=0, `fifos_full`=0, `fifos_error`=0, all data outputs 0.
- **Fill and flags, FIFO 0:** push 12'h34C, 12'h2CC, 12'hB4C, … on 8 consecutive cycles →
  - `fifos_empty[0]` falls after the 1st push;
  - `fifos_almost_full[0]` rises after the 6th push;
  - `fifos_full[0]` rises after the 8th push;
  - a 9th push sets `fifos_error[0]` and does not overwrite entry 0.
- **Order and wrap-around, FIFO 2:** push 6, pop 6, push 6, pop 6 with distinct values → outputs match push order exactly, each 1 cycle after its pop. Pointers wrap past 7 with no error.
- **Simultaneous events:**
  - full FIFO 1 with push and pop together → count stays 8, no error, oldest word output;
  - empty FIFO 3 with push and pop together → count becomes 1, `fifos_error[3]`=1.
- **Independence:** `fifos_push`=4'b1010 with data 12'hF0F → only FIFOs 1 and 3 go non-empty. A later pop on each yields 12'hF0F.
- **Reset mid-operation:** FIFO 0 holds 5 words; assert `reset` in the same cycle as push and pop → empty=1, count=0, output=0. The next push then pop returns the new word, not stale memory.
